fp16_mult_result_stage: RTL and testbench
=========================================

// Module: fp16_mult_result_stage
// PURPOSE
//  Registered output stage directly downstream of the combinational half-precision multiplier.
//  - Captures each 16-bit product with a tag into a DEPTH-entry FIFO.
//  - Classifies the product and attaches per-result flags.
//  - Accumulates sticky exception flags and counts delivered results.
//  - Uses a valid/ready handshake on both sides so the multiplier can be issued back-to-back.
// PARAMETERS
//  DEPTH  2   FIFO entries; power of two, >=2
//  TAG_W  4   width of the opaque tag carried alongside each product
//  CNT_W  16  width of the saturating result counter
// PORTS
//  CLK         in   1      clock, all state updates on posedge
//  rst         in   1      synchronous active-high reset
//  in_valid    in   1      product from multiplier is valid
//  in_ready    out  1      stage can accept; in_ready = (count != DEPTH)
//  in_product  in   16     multiplier product {sign, exp[4:0], mant[9:0]}
//  in_tag      in   TAG_W  tag issued with the operands
//  out_valid   out  1      head entry valid; out_valid = (count != 0)
//  out_ready   in   1      consumer accepts head entry
//  out_product out  16     head product (possibly canonicalised, see CONFIGURATION)
//  out_tag     out  TAG_W  head tag
//  out_flags   out  4      head flags {OF, NV, INF, SUB}
//  fflags      out  4      sticky OR of accepted flags, same bit order
//  fflags_clr  in   1      clears fflags
//  result_cnt  out  CNT_W  number of popped results, saturating
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptr=0, fflags=0, result_cnt=0.
//    out_valid=0, in_ready=1. out_product, out_tag and out_flags read 0 while empty.
//  - Push: in_valid & in_ready. Pop: out_valid & out_ready.
//    Both happen at posedge. Push-to-out_valid latency = 1 cycle.
//  - Ptrs are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//    Simultaneous push and pop leaves count unchanged.
//  - Full: in_ready=0 even if out_ready=1 this cycle. There is no same-cycle bypass; the
//    offered product is held upstream.
//  - Empty: a pop is impossible. A push while empty is visible the next cycle.
//  - Classification is evaluated on in_product at push and stored with the entry. The first
//    matching rule sets its flag:
//      OF  : product == 16'hFDFF (multiplier exponent-overflow encoding)
//      NV  : exp == 5'h1F & mant != 0, excluding the OF pattern
//      INF : exp == 5'h1F & mant == 0
//      SUB : exp == 0 & mant != 0
//    Zero and normal products set no flag. Exactly one flag or none is set per entry.
//  - fflags_next = (fflags_clr ? 0 : fflags) | (push ? new_flags : 0).
//    A flag set in the same cycle as fflags_clr survives.
//  - result_cnt increments on each pop and holds at all-ones.
//  - rst asserted mid-stream discards all entries at the next posedge. No partial state
//    survives. in_valid during rst is ignored.
// CONFIGURATION
//  - FP16_MULT_CANON_NAN_EN defined: at push, any entry flagged OF or NV stores
//    out_product = 16'h7E00 (canonical qNaN). Flags are unchanged.
//  - Not defined: the product is stored bit-exact.
// STRUCTURE
//  - fpu_types_pkg gains:
//      typedef enum logic [1:0] {FP16_NORM, FP16_SUB, FP16_INF, FP16_NAN} fp16_class_t;
//      HALF_MULT_OVF = 16'hFDFF; HALF_CANON_QNAN = 16'h7E00.
//  - One combinational sub-module, fp16_result_classify: 16-bit product in, 4-bit flags out.
//    It is instantiated once on the push path. FIFO storage and pointers stay in this module.
// TESTING
//  1. Reset, then push 16'h3C00 (tag 1) with out_ready=1.
//     -> out_valid the next cycle, out_product=16'h3C00, out_tag=1, out_flags=0,
//        result_cnt=1 after the pop.
//  2. Hold out_ready=0 and push three times, DEPTH=2.
//     -> in_ready drops after two accepts, the third product is held.
//     Release out_ready -> order 1,2,3 preserved, with a ptr wrap.
//  3. Push 16'hFDFF -> out_flags=4'b1000, fflags[3]=1.
//     Then push 16'hFFFF -> out_flags=4'b0100.
//     With FP16_MULT_CANON_NAN_EN both read 16'h7E00, else bit-exact.
//  4. Push 16'h7C00 -> INF; push 16'h0001 -> SUB.
//     Then assert fflags_clr in the same cycle as pushing 16'hFC00 -> fflags=4'b0010.
//  5. Full FIFO with out_ready=1 and in_valid=1 -> one pop and no push that cycle;
//     count goes to DEPTH-1.
//  6. Assert rst with 2 entries queued -> next cycle out_valid=0, fflags=0,
//     result_cnt=0, in_ready=1.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared FP16 result-stage types, constants and the product classification helper.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package fpu_types_pkg;

    typedef enum logic [1:0] {
        FP16_NORM,
        FP16_SUB,
        FP16_INF,
        FP16_NAN
    } fp16_class_t;

    // Encoding the multiplier emits when the exponent overflows.
    localparam logic [15:0] HALF_MULT_OVF   = 16'hFDFF;
    localparam logic [15:0] HALF_CANON_QNAN = 16'h7E00;

    // Bit positions inside the 4-bit flag vector {OF, NV, INF, SUB}.
    localparam int FLAG_OF  = 3;
    localparam int FLAG_NV  = 2;
    localparam int FLAG_INF = 1;
    localparam int FLAG_SUB = 0;

    // Zero is reported as FP16_NORM: it carries no exception flag.
    function automatic fp16_class_t fp16_class(input logic [15:0] p);
        logic [4:0] e;
        logic [9:0] m;
        e = p[14:10];
        m = p[9:0];
        if (e == 5'h1F) begin
            return (m != 10'd0) ? FP16_NAN : FP16_INF;
        end else if (e == 5'h00 && m != 10'd0) begin
            return FP16_SUB;
        end
        return FP16_NORM;
    endfunction

endpackage

// File: rtl/fp16_result_classify.sv
// Classifies one FP16 multiplier product into a one-hot-or-zero flag vector {OF, NV, INF, SUB}.
// Latency: purely combinational.
// Backpressure: none; output follows the input every cycle.
//
// Ports:
//   product  in   16  product {sign, exp[4:0], mant[9:0]}
//   flags    out  4   {OF, NV, INF, SUB}; at most one bit set
module fp16_result_classify
    import fpu_types_pkg::*;
(
    input  logic [15:0] product,
    output logic [3:0]  flags
);

    fp16_class_t cls;

    always_comb begin
        flags = 4'b0000;
        cls   = fp16_class(product);
        // The overflow encoding is itself a NaN pattern, so it must win before NV.
        if (product == HALF_MULT_OVF) begin
            flags[FLAG_OF] = 1'b1;
        end else begin
            case (cls)
                FP16_NAN: flags[FLAG_NV]  = 1'b1;
                FP16_INF: flags[FLAG_INF] = 1'b1;
                FP16_SUB: flags[FLAG_SUB] = 1'b1;
                default:  flags           = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/fp16_mult_result_stage.sv
// Registered FIFO stage behind the FP16 multiplier: stores product+tag+flags, keeps sticky
// fflags and a saturating delivered-result counter.
// Latency: 1 cycle push-to-out_valid. Backpressure: in_ready = not full; no same-cycle bypass.
//
// Optional feature macro: FP16_MULT_CANON_NAN_EN -- when defined, OF/NV entries are stored as
// the canonical qNaN 16'h7E00 (flags unchanged); otherwise products are stored bit-exact.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_product, in_tag accompany it
//   out_valid/out_ready downstream handshake; out_product, out_tag, out_flags read 0 when empty
//   fflags, fflags_clr  sticky OR of pushed flags; clear input (same-cycle new flags survive)
//   result_cnt          number of pops, saturating at all-ones
module fp16_mult_result_stage
    import fpu_types_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic [3:0]       fflags,
    input  logic             fflags_clr,
    output logic [CNT_W-1:0] result_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

    logic [15:0]      prod_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [3:0]       flag_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] count;

    logic        push;
    logic        pop;
    logic [3:0]  new_flags;
    logic        canon_sel;
    logic [15:0] store_product;

    assign in_ready  = (count != FULL_LVL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    fp16_result_classify u_classify (
        .product (in_product),
        .flags   (new_flags)
    );

`ifdef FP16_MULT_CANON_NAN_EN
    assign canon_sel = new_flags[FLAG_OF] | new_flags[FLAG_NV];
`else
    assign canon_sel = 1'b0;
`endif

    assign store_product = canon_sel ? HALF_CANON_QNAN : in_product;

    // Storage carries no reset; stale contents are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (push) begin
            prod_mem[wr_ptr] <= store_product;
            tag_mem[wr_ptr]  <= in_tag;
            flag_mem[wr_ptr] <= new_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fflags     <= '0;
            result_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase
            // Clear first, then OR in this cycle's flags so a coincident exception is kept.
            fflags <= (fflags_clr ? 4'b0000 : fflags) | (push ? new_flags : 4'b0000);
            if (pop && (result_cnt != '1)) begin
                result_cnt <= result_cnt + CNT_W'(1);
            end
        end
    end

    assign out_product = out_valid ? prod_mem[rd_ptr] : 16'h0000;
    assign out_tag     = out_valid ? tag_mem[rd_ptr]  : '0;
    assign out_flags   = out_valid ? flag_mem[rd_ptr] : 4'b0000;

endmodule

// File: tb/tb_fp16_mult_result_stage.sv
module tb_fp16_mult_result_stage;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_product;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_product;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;
    logic [3:0]       fflags;
    logic             fflags_clr;
    logic [CNT_W-1:0] result_cnt;

    fp16_mult_result_stage #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_product  (in_product),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .out_flags   (out_flags),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr),
        .result_cnt  (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [3:0]       exp_fflags = 4'b0000;
    logic [CNT_W-1:0] exp_cnt    = '0;

    typedef struct {
        logic [15:0]      prod;
        logic [TAG_W-1:0] tag;
        logic [15:0]      exp_prod;
        logic [3:0]       exp_flags;
    } vec_t;

    vec_t vecs [10];

`ifdef FP16_MULT_CANON_NAN_EN
    localparam logic [15:0] NAN_FDFF = 16'h7E00;
    localparam logic [15:0] NAN_FFFF = 16'h7E00;
    localparam logic [15:0] NAN_7C01 = 16'h7E00;
`else
    localparam logic [15:0] NAN_FDFF = 16'hFDFF;
    localparam logic [15:0] NAN_FFFF = 16'hFFFF;
    localparam logic [15:0] NAN_7C01 = 16'h7C01;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (exp_cnt != '1) exp_cnt++;
        chk("result_cnt_after_pop", 32'(result_cnt), 32'(exp_cnt));
    endtask

    initial begin
        vecs[0] = '{16'h3C00, 4'h2, 16'h3C00, 4'b0000};
        vecs[1] = '{16'hFDFF, 4'h3, NAN_FDFF, 4'b1000};
        vecs[2] = '{16'hFFFF, 4'h4, NAN_FFFF, 4'b0100};
        vecs[3] = '{16'h7C00, 4'h5, 16'h7C00, 4'b0010};
        vecs[4] = '{16'h0001, 4'h6, 16'h0001, 4'b0001};
        vecs[5] = '{16'h0000, 4'h7, 16'h0000, 4'b0000};
        vecs[6] = '{16'h8400, 4'h8, 16'h8400, 4'b0000};
        vecs[7] = '{16'h7C01, 4'h9, NAN_7C01, 4'b0100};
        vecs[8] = '{16'h03FF, 4'hA, 16'h03FF, 4'b0001};
        vecs[9] = '{16'hFC00, 4'hB, 16'hFC00, 4'b0010};

        rst = 1'b1; in_valid = 1'b0; in_product = '0; in_tag = '0;
        out_ready = 1'b0; fflags_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_product", 32'(out_product), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_fflags", 32'(fflags), 32'd0);
        chk("rst_result_cnt", 32'(result_cnt), 32'd0);

        // Single push with out_ready already high
        in_valid = 1'b1; in_product = 16'h3C00; in_tag = 4'h1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_product", 32'(out_product), 32'h3C00);
        chk("t1_out_tag", 32'(out_tag), 32'd1);
        chk("t1_out_flags", 32'(out_flags), 32'd0);
        step();
        out_ready = 1'b0;
        exp_cnt = 1;
        chk("t1_empty_after_pop", 32'(out_valid), 32'd0);
        chk("t1_result_cnt", 32'(result_cnt), 32'd1);

        // Classification table
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_product = vecs[i].prod; in_tag = vecs[i].tag;
            step();
            in_valid = 1'b0;
            exp_fflags |= vecs[i].exp_flags;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_out_product", i), 32'(out_product), 32'(vecs[i].exp_prod));
            chk($sformatf("vec%0d_out_tag", i), 32'(out_tag), 32'(vecs[i].tag));
            chk($sformatf("vec%0d_out_flags", i), 32'(out_flags), 32'(vecs[i].exp_flags));
            chk($sformatf("vec%0d_fflags", i), 32'(fflags), 32'(exp_fflags));
            pop_one();
        end

        // fflags_clr coincident with a flagged push: new INF flag survives
        in_valid = 1'b1; in_product = 16'hFC00; in_tag = 4'hC; fflags_clr = 1'b1;
        step();
        in_valid = 1'b0; fflags_clr = 1'b0;
        chk("clr_push_fflags", 32'(fflags), 32'b0010);
        pop_one();
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_only_fflags", 32'(fflags), 32'd0);

        // Fill to DEPTH, hold third product, full-with-pop, then push+pop with ptr wrap
        in_valid = 1'b1; in_product = 16'h1111; in_tag = 4'h1;
        step();
        chk("fill1_in_ready", 32'(in_ready), 32'd1);
        in_product = 16'h2222; in_tag = 4'h2;
        step();
        chk("fill2_in_ready", 32'(in_ready), 32'd0);
        in_product = 16'h3333; in_tag = 4'h3;
        step();
        chk("held_in_ready", 32'(in_ready), 32'd0);
        chk("held_head_tag", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        step();
        if (exp_cnt != '1) exp_cnt++;
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        chk("full_pop_out_valid", 32'(out_valid), 32'd1);
        chk("full_pop_head_tag", 32'(out_tag), 32'd2);
        chk("full_pop_head_prod", 32'(out_product), 32'h2222);
        step();
        if (exp_cnt != '1) exp_cnt++;
        in_valid = 1'b0;
        chk("pushpop_head_tag", 32'(out_tag), 32'd3);
        chk("pushpop_head_prod", 32'(out_product), 32'h3333);
        chk("pushpop_in_ready", 32'(in_ready), 32'd1);
        step();
        if (exp_cnt != '1) exp_cnt++;
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_result_cnt", 32'(result_cnt), 32'(exp_cnt));

        // Drive result_cnt past all-ones to see it saturate
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_product = 16'h4000; in_tag = 4'(i);
            step();
            in_valid = 1'b0;
            pop_one();
        end
        chk("sat_result_cnt", 32'(result_cnt), 32'hF);

        // Reset with two entries queued; in_valid during reset ignored
        in_valid = 1'b1; in_product = 16'h7C00; in_tag = 4'h5;
        step(); step();
        chk("prerst_in_ready", 32'(in_ready), 32'd0);
        chk("prerst_fflags", 32'(fflags), 32'b0010);
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_fflags", 32'(fflags), 32'd0);
        chk("midrst_result_cnt", 32'(result_cnt), 32'd0);
        chk("midrst_out_product", 32'(out_product), 32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("postrst_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
